// File: rtl/score_pkg.sv
// Shared encodings and constants for the score keeper and its BCD converter.
package score_pkg;

  typedef enum logic [1:0] {
    ST_TITLE     = 2'b00,
    ST_PLAY      = 2'b01,
    ST_OVER      = 2'b10,
    ST_TITLE_ALT = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    HIT_LARGE  = 2'd0,
    HIT_MEDIUM = 2'd1,
    HIT_SMALL  = 2'd2,
    HIT_NONE   = 2'd3
  } hit_size_e;

  localparam int unsigned DEF_PTS_LARGE  = 1;
  localparam int unsigned DEF_PTS_MEDIUM = 2;
  localparam int unsigned DEF_PTS_SMALL  = 5;
  localparam int unsigned DEF_LIFE_STEP  = 100;
  localparam int unsigned DEF_SCORE_MAX  = 255;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_e;

  // One double-dabble step on {hundreds, tens, ones, binary}: correct digits, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int n = 0; n < 3; n++) begin
      if (adj[8+4*n +: 4] >= 4'd5) begin
        adj[8+4*n +: 4] = adj[8+4*n +: 4] + 4'd3;
      end
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Score interface: game-side strobes in, score/high-score/BCD display words out.
interface score_keeper_if;
  logic [1:0]  state_set;
  logic        hit_valid;
  logic [1:0]  hit_size;
  logic [7:0]  score;
  logic [7:0]  high_score;
  logic [11:0] score_bcd;
  logic        bcd_busy;
  logic        extra_life;

  modport master (
    output state_set, hit_valid, hit_size,
    input  score, high_score, score_bcd, bcd_busy, extra_life
  );

  modport slave (
    input  state_set, hit_valid, hit_size,
    output score, high_score, score_bcd, bcd_busy, extra_life
  );
endinterface

// File: rtl/score_keeper_bcd_seq_conv.sv
// Sequential 8-bit to 3-digit BCD converter: one load cycle, then eight dabble shifts.
module bcd_seq_conv
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] sr_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    sr_shift = dabble_step(sr_q);
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          sr_d    = {12'd0, bin};
          cnt_d   = 3'd0;
          state_d = CONV_RUN;
        end
      end
      CONV_RUN: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 3'd1;
        // The eighth shift is the last; its result is handed out combinationally.
        if (cnt_q == 3'd7) begin
          done    = 1'b1;
          state_d = CONV_IDLE;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  assign busy = (state_q == CONV_RUN);
  assign bcd  = sr_shift[19:8];

endmodule

// File: rtl/score_keeper.sv
// Score accumulation, extra-life pulses, session high score and a stable BCD
// copy of the score for the digit renderers.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned PTS_LARGE  = DEF_PTS_LARGE,
  parameter int unsigned PTS_MEDIUM = DEF_PTS_MEDIUM,
  parameter int unsigned PTS_SMALL  = DEF_PTS_SMALL,
  parameter int unsigned LIFE_STEP  = DEF_LIFE_STEP,
  parameter int unsigned SCORE_MAX  = DEF_SCORE_MAX
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  sk
);

  localparam logic [8:0] MAX9  = 9'(SCORE_MAX);
  localparam logic [8:0] STEP9 = 9'(LIFE_STEP);

  logic [1:0]  prev_state_q;
  logic [7:0]  score_q, score_d;
  logic [7:0]  high_q, high_d;
  logic [7:0]  snap_q, snap_d;
  logic [8:0]  next_life_q, next_life_d;
  logic        hit_q, hit_d;
  logic        life_q, life_d;
  logic [11:0] bcd_q, bcd_d;

  logic        in_play, new_game, enter_over;
  logic [7:0]  pts;
  logic [8:0]  sum9;
  logic        conv_start, conv_busy, conv_done;
  logic [11:0] conv_bcd;

  function automatic logic [7:0] points(input logic [1:0] sz);
    case (sz)
      HIT_LARGE:  return 8'(PTS_LARGE);
      HIT_MEDIUM: return 8'(PTS_MEDIUM);
      HIT_SMALL:  return 8'(PTS_SMALL);
      default:    return 8'd0;
    endcase
  endfunction

  always_comb begin
    in_play     = (sk.state_set == ST_PLAY);
    new_game    = in_play && (prev_state_q != ST_PLAY);
    enter_over  = (sk.state_set == ST_OVER) && (prev_state_q != ST_OVER);
    pts         = points(sk.hit_size);
    sum9        = {1'b0, score_q} + {1'b0, pts};
    score_d     = score_q;
    next_life_d = next_life_q;
    hit_d       = 1'b0;
    life_d      = 1'b0;
    if (new_game) begin
      score_d     = 8'd0;
      next_life_d = STEP9;
    end else begin
      // Threshold is checked the cycle after a hit lands, so at most one pulse per hit.
      if (hit_q && ({1'b0, score_q} >= next_life_q) && (next_life_q <= MAX9)) begin
        life_d      = 1'b1;
        next_life_d = next_life_q + STEP9;
      end
      if (in_play && sk.hit_valid) begin
        score_d = (sum9 > MAX9) ? MAX9[7:0] : sum9[7:0];
        hit_d   = 1'b1;
      end
    end

    high_d     = (enter_over && (score_q > high_q)) ? score_q : high_q;
    conv_start = !conv_busy && (score_q != snap_q);
    snap_d     = conv_start ? score_q : snap_q;
    bcd_d      = conv_done ? conv_bcd : bcd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state_q <= ST_TITLE;
      score_q      <= '0;
      high_q       <= '0;
      snap_q       <= '0;
      next_life_q  <= STEP9;
      hit_q        <= 1'b0;
      life_q       <= 1'b0;
      bcd_q        <= '0;
    end else begin
      prev_state_q <= sk.state_set;
      score_q      <= score_d;
      high_q       <= high_d;
      snap_q       <= snap_d;
      next_life_q  <= next_life_d;
      hit_q        <= hit_d;
      life_q       <= life_d;
      bcd_q        <= bcd_d;
    end
  end

  bcd_seq_conv u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (score_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign sk.score      = score_q;
  assign sk.high_score = high_q;
  assign sk.score_bcd  = bcd_q;
  assign sk.bcd_busy   = conv_busy;
  assign sk.extra_life = life_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: spec-level model plus directed literal checks.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if sk();

  score_keeper dut (
    .clk (clk),
    .rst (rst),
    .sk  (sk)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int pts_of(input logic [1:0] sz);
    case (sz)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Specification-level model: score, high score and life pulses
  int m_score, m_high, m_next, m_prev, st;
  bit m_life, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_score = 0; m_high = 0; m_next = 100; m_prev = 0; m_life = 0; m_pend = 0;
    end else begin
      st = int'(sk.state_set);
      m_life = m_pend;
      m_pend = 0;
      if (st == 1 && m_prev != 1) begin
        m_score = 0;
        m_next  = 100;
        m_life  = 0;
      end else if (st == 1 && sk.hit_valid) begin
        m_score = m_score + pts_of(sk.hit_size);
        if (m_score > 255) m_score = 255;
        if (m_next <= 255 && m_score >= m_next) begin
          m_pend = 1;
          m_next = m_next + 100;
        end
      end
      if (st == 2 && m_prev != 2 && m_score > m_high) m_high = m_score;
      m_prev = st;
    end
  end

  // Per-cycle compare: model outputs, BCD legality and settling
  bit seen[256];
  int since, last_score, n_pulses;
  logic [11:0] last_bcd;

  function automatic bit bcd_legal(input logic [11:0] b);
    int v;
    if (b[11:8] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9) return 0;
    v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    return seen[v];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      foreach (seen[i]) seen[i] = 0;
      seen[0] = 1; since = 0; last_score = 0; last_bcd = '0;
    end else begin
      check("score", int'(sk.score), m_score);
      check("high_score", int'(sk.high_score), m_high);
      check("extra_life", int'(sk.extra_life), int'(m_life));
      seen[sk.score] = 1;
      if (int'(sk.score) != last_score) since = 0;
      else since++;
      last_score = int'(sk.score);
      if (sk.score_bcd != last_bcd) begin
        check("bcd_legal", int'(bcd_legal(sk.score_bcd)), 1);
        last_bcd = sk.score_bcd;
      end
      if (since == 18) begin
        check("bcd_settled", int'(sk.score_bcd), int'(to_bcd(int'(sk.score))));
        check("busy_idle", int'(sk.bcd_busy), 0);
      end
      if (sk.extra_life) n_pulses++;
    end
  end

  task automatic tick(input logic [1:0] s, input logic hv, input logic [1:0] hs);
    sk.state_set = s;
    sk.hit_valid = hv;
    sk.hit_size  = hs;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_score"}, int'(sk.score), 0);
    check({tag, "_high"}, int'(sk.high_score), 0);
    check({tag, "_bcd"}, int'(sk.score_bcd), 0);
    check({tag, "_busy"}, int'(sk.bcd_busy), 0);
    check({tag, "_life"}, int'(sk.extra_life), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit saw_busy;
    n_pulses = 0;
    sk.state_set = 2'b00; sk.hit_valid = 1'b0; sk.hit_size = 2'b00;
    #1 rst = 1'b1;
    #2 reset_check("por");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Scoring on consecutive hits and BCD settling
    tick(2'b00, 0, 0);
    tick(2'b01, 0, 0);
    tick(2'b01, 1, 2); check("t2_score5", int'(sk.score), 5);
    tick(2'b01, 1, 2); check("t2_score10", int'(sk.score), 10);
    tick(2'b01, 1, 1); check("t2_score12", int'(sk.score), 12);
    saw_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick(2'b01, 0, 0);
      if (sk.bcd_busy) saw_busy = 1;
    end
    check("t2_saw_busy", int'(saw_busy), 1);
    check("t2_bcd012", int'(sk.score_bcd), 12'h012);

    // hit_size 3 scores nothing and starts no conversion
    for (int i = 0; i < 5; i++) begin
      tick(2'b01, 1, 3);
      check("t6_busy", int'(sk.bcd_busy), 0);
    end
    check("t6_score", int'(sk.score), 12);

    // High score and game-state transitions
    tick(2'b10, 0, 0); check("t5_high12", int'(sk.high_score), 12);
    tick(2'b01, 0, 0);
    for (int i = 0; i < 6; i++) tick(2'b01, 1, 2);
    tick(2'b10, 0, 0); check("t5_high30", int'(sk.high_score), 30);
    tick(2'b01, 0, 0);
    for (int i = 0; i < 8; i++) tick(2'b01, 1, 2);
    check("t5_score40", int'(sk.score), 40);
    tick(2'b10, 0, 0); check("t5_high40", int'(sk.high_score), 40);
    for (int i = 0; i < 3; i++) tick(2'b10, 1, 2);
    check("t5_frozen", int'(sk.score), 40);
    tick(2'b01, 1, 2); check("t5_newgame", int'(sk.score), 0);
    tick(2'b01, 0, 0); check("t5_hit_dropped", int'(sk.score), 0);
    for (int i = 0; i < 4; i++) tick(2'b01, 1, 2);
    tick(2'b10, 0, 0);
    check("t5_score20", int'(sk.score), 20);
    check("t5_high_kept", int'(sk.high_score), 40);

    // Extra-life thresholds
    base = n_pulses;
    tick(2'b01, 0, 0);
    for (int i = 0; i < 19; i++) tick(2'b01, 1, 2);
    tick(2'b01, 1, 0);
    tick(2'b01, 1, 1); check("t4_score98", int'(sk.score), 98);
    tick(2'b01, 1, 2); check("t4_score103", int'(sk.score), 103);
    tick(2'b01, 0, 0); tick(2'b01, 0, 0);
    check("t4_pulse1", n_pulses - base, 1);
    for (int i = 0; i < 19; i++) tick(2'b01, 1, 2);
    tick(2'b01, 1, 0);
    tick(2'b01, 1, 0); check("t4_score200", int'(sk.score), 200);
    tick(2'b01, 0, 0); tick(2'b01, 0, 0);
    check("t4_pulse2", n_pulses - base, 2);
    for (int i = 0; i < 11; i++) tick(2'b01, 1, 2);
    check("t4_score255", int'(sk.score), 255);
    for (int i = 0; i < 3; i++) tick(2'b01, 0, 0);
    check("t4_no_pulse3", n_pulses - base, 2);

    // Saturation
    tick(2'b00, 0, 0);
    tick(2'b01, 0, 0);
    for (int i = 0; i < 50; i++) tick(2'b01, 1, 2);
    check("t3_score250", int'(sk.score), 250);
    tick(2'b01, 1, 2); check("t3_sat_a", int'(sk.score), 255);
    tick(2'b01, 1, 2); check("t3_sat_b", int'(sk.score), 255);
    tick(2'b01, 1, 0); check("t3_sat_c", int'(sk.score), 255);
    for (int i = 0; i < 20; i++) tick(2'b01, 0, 0);
    check("t3_bcd255", int'(sk.score_bcd), 12'h255);

    // Asynchronous reset in the middle of a conversion
    tick(2'b00, 0, 0);
    tick(2'b01, 0, 0);
    tick(2'b01, 1, 2);
    tick(2'b01, 0, 0);
    tick(2'b01, 0, 0);
    check("t1_busy_before", int'(sk.bcd_busy), 1);
    #2 rst = 1'b1;
    #1 reset_check("t1_async");
    @(negedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(2'b00, 0, 0);
    reset_check("t1_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Producer side of the score interface. Accumulates points from asteroid-hit events during play and holds the session high score. Converts the current score to 3-digit BCD with a sequential double-dabble, publishing a stable BCD word for the on-screen digit renderers. Sits between the collision/game-state logic and the score display blocks.

Parameters:
PTS_LARGE, 1, points for hit_size 0 (large asteroid)
PTS_MEDIUM, 2, points for hit_size 1
PTS_SMALL, 5, points for hit_size 2
LIFE_STEP, 100, score interval that awards an extra life
SCORE_MAX, 255, saturation ceiling (must be <= 255)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-high reset
state_set  in  2  game state: 00 title, 01 play, 10 game over, 11 treated as title
hit_valid  in  1  one-cycle hit event strobe
hit_size  in  2  asteroid size for the hit; 3 = no points
score  out  8  current score, registered
high_score  out  8  best score since reset, registered
score_bcd  out  12  BCD of last fully converted score {hundreds, tens, ones}
bcd_busy  out  1  conversion in progress
extra_life  out  1  one-cycle pulse on crossing a LIFE_STEP multiple

Behaviour:
- Reset (async, rst=1): score=0, high_score=0, score_bcd=12'h000, bcd_busy=0, extra_life=0, next_life=LIFE_STEP, conv FSM=IDLE, snapshot=0, prev_state=00.
- prev_state register tracks state_set every clk.
- New game: state_set==01 && prev_state!=01 -> score<=0, next_life<=LIFE_STEP. Takes priority over a same-cycle hit (the hit is dropped).
- Scoring only while state_set==01. hit_valid=1 -> score <= min(score + pts(hit_size), SCORE_MAX); 1-clk latency. Sum computed 9-bit before the clamp. hit_size 3 adds 0. One hit per clk, and a hit on every consecutive clk is accepted.
- Outside play, hits are ignored and score is frozen.
- Extra life: next_life is 9 bits. When the updated score >= next_life: extra_life pulses for 1 clk, registered on the cycle after the score update. next_life += LIFE_STEP.
  - next_life > SCORE_MAX -> no further pulses.
  - Only one pulse per hit, even if a single add crosses two thresholds (not possible with defaults).
- High score: on entry to game over (state_set==10 && prev_state!=10), high_score <= max(high_score, score). Never cleared except by rst.
- BCD conversion FSM:
  - IDLE: if score != snapshot -> snapshot<=score, load shift reg {12'b0, score}, cnt<=0, bcd_busy<=1, go CONV.
  - CONV: per clk, add 3 to each BCD nibble >= 5, then shift left 1; cnt++. At cnt==7 the shift completes, score_bcd <= result, bcd_busy<=0, go IDLE.
  - Timing: score changes at edge E, load at E+1, eight shifts at E+2..E+9, score_bcd valid after edge E+9.
  - score_bcd changes atomically, only on completion, and never shows partial values.
  - A score change during CONV does not abort. The mismatch is caught in IDLE on the next cycle and reconverted, so score_bcd converges to the final score within 18 clks of the last change.
- Async rst mid-CONV returns everything to reset values immediately.

Decomposition:
- Shared package score_pkg: state_set encodings (ST_TITLE, ST_PLAY, ST_OVER), hit_size encodings, default point constants, conv FSM state typedef.
- One sub-module, bcd_seq_conv: clk, rst, start, bin[7:0] -> busy, done, bcd[11:0]. It holds the shift register, counter and IDLE/CONV FSM.
- score_keeper instantiates bcd_seq_conv and owns the snapshot compare, scoring, life and high-score logic.

Test Plan:
1. Assert rst mid-run, including mid-CONV -> score=0, high_score=0, score_bcd=000, bcd_busy=0, extra_life=0 immediately, without waiting for a clk edge.
2. state 00->01, hits of size 2,2,1 on consecutive clks -> score 5,10,12. bcd_busy asserts, and score_bcd settles to 12'h012 within 18 clks of the last hit with no intermediate garbage.
3. Score 250, hit size 2 twice -> 255, 255. score_bcd=12'h255. A further size-0 hit keeps 255.
4. Score 98, hit size 2 -> score 103 and exactly one extra_life pulse. Continue to 200 -> second pulse. Reaching 255 -> no third pulse.
5. Score 40 with high_score 30, state 01->10 -> high_score=40. Hits in state 10 leave score=40. state 10->01 with a hit on the same clk -> score=0, the hit is dropped. A later game over at score 20 leaves high_score=40.
6. hit_size=3 pulses in play -> score unchanged, no conversion started (bcd_busy stays 0).
